// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, IF/ID pipeline
// register and a two-state RUN/HALTED fetch FSM.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is
// defined; otherwise the counter ports are tied to zero.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_enable,
   input  logic        instr_enable,
   input  logic        pc_src,
   input  logic        jumpD,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   input  logic [31:0] instr_mem_data,
   output logic [31:0] pc_out,
   output logic [31:0] instrD,
   output logic [31:0] pc_plus4D,
   output logic        validD,
   output logic        halted,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt,
   output logic [31:0] fetch_cnt
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc_next;
   logic [31:0] pc_plus4;
   logic        redirect;
   logic        in_run;
   logic        do_flush;
   logic        do_load;
   logic        halt_load;

   // Redirects in decode squash whatever is being fetched this cycle; a
   // HALT_WORD only stops fetch when it is actually captured into IF/ID.
   assign pc_plus4  = pc_out + 32'd4;
   assign redirect  = pc_src | jumpD;
   assign in_run    = (state == RUN);
   assign do_flush  = in_run && instr_enable && redirect;
   assign do_load   = in_run && instr_enable && !redirect;
   assign halt_load = do_load && (instr_mem_data == HALT_WORD);
   assign halted    = (state == HALTED);

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state: HALTED is left only through reset
   always_comb begin
      state_next = state;
      if (in_run && halt_load) begin
         state_next = HALTED;
      end
   end

   // Next-PC select; the PC also holds on the halting edge so it stays at the HALT_WORD address
   always_comb begin
      pc_next = pc_out;
      if (!in_run || !pc_enable || halt_load) begin
         pc_next = pc_out;
      end else if (jumpD) begin
         pc_next = jump_target;
      end else if (pc_src) begin
         pc_next = branch_target;
      end else begin
         pc_next = pc_plus4;
      end
   end

   // PC register
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_out <= RESET_PC;
      end else begin
         pc_out <= pc_next;
      end
   end

   // IF/ID register: hold, then bubble in HALTED, then flush, then load
   always_ff @(posedge clk) begin
      if (reset) begin
         instrD    <= 32'h0;
         pc_plus4D <= 32'h0;
         validD    <= 1'b0;
      end else if (!instr_enable) begin
         instrD    <= instrD;
         pc_plus4D <= pc_plus4D;
         validD    <= validD;
      end else if (!in_run || do_flush) begin
         instrD    <= 32'h0;
         pc_plus4D <= 32'h0;
         validD    <= 1'b0;
      end else begin
         instrD    <= instr_mem_data;
         pc_plus4D <= pc_plus4;
         validD    <= 1'b1;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Performance counters: stalls in RUN, flush cycles and real loads; all wrap at 2^32
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= 32'h0;
         flush_cnt <= 32'h0;
         fetch_cnt <= 32'h0;
      end else begin
         if (in_run && !pc_enable) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (do_flush) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
         if (do_load) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
      end
   end
`else
   assign stall_cnt = 32'h0;
   assign flush_cnt = 32'h0;
   assign fetch_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (default parameters).
// Counter expectations fold to zero unless FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        pc_enable;
   logic        instr_enable;
   logic        pc_src;
   logic        jumpD;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] instr_mem_data;
   logic [31:0] pc_out;
   logic [31:0] instrD;
   logic [31:0] pc_plus4D;
   logic        validD;
   logic        halted;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
   logic [31:0] fetch_cnt;

   logic        override_en;
   logic [31:0] override_addr;
   logic [31:0] override_data;

   int vectors;
   int miscompares;

   fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .pc_enable      (pc_enable),
      .instr_enable   (instr_enable),
      .pc_src         (pc_src),
      .jumpD          (jumpD),
      .branch_target  (branch_target),
      .jump_target    (jump_target),
      .instr_mem_data (instr_mem_data),
      .pc_out         (pc_out),
      .instrD         (instrD),
      .pc_plus4D      (pc_plus4D),
      .validD         (validD),
      .halted         (halted),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt),
      .fetch_cnt      (fetch_cnt)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: word i lives at address 4i, with one patchable location
   always_comb begin
      instr_mem_data = pc_out >> 2;
      if (override_en && (pc_out == override_addr)) begin
         instr_mem_data = override_data;
      end
   end

   function automatic logic [31:0] cntExp(input logic [31:0] v);
`ifdef FETCH_PERF_CNT_EN
      return v;
`else
      return 32'h0 & v;
`endif
   endfunction

   task automatic applyStimulus(input logic rst, input logic pe, input logic ie,
                                input logic ps, input logic jd,
                                input logic [31:0] bt, input logic [31:0] jt);
      reset         = rst;
      pc_enable     = pe;
      instr_enable  = ie;
      pc_src        = ps;
      jumpD         = jd;
      branch_target = bt;
      jump_target   = jt;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic checkState(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                             input logic [31:0] p4, input logic v, input logic h);
      checkOutput({tag, ".pc"},     pc_out,           pc);
      checkOutput({tag, ".instr"},  instrD,           ins);
      checkOutput({tag, ".pc4"},    pc_plus4D,        p4);
      checkOutput({tag, ".valid"},  {31'h0, validD},  {31'h0, v});
      checkOutput({tag, ".halted"}, {31'h0, halted},  {31'h0, h});
   endtask

   task automatic checkCounters(input string tag, input logic [31:0] s,
                                input logic [31:0] f, input logic [31:0] fe);
      checkOutput({tag, ".stall"}, stall_cnt, cntExp(s));
      checkOutput({tag, ".flush"}, flush_cnt, cntExp(f));
      checkOutput({tag, ".fetch"}, fetch_cnt, cntExp(fe));
   endtask

   // Directed sequence
   initial begin
      vectors       = 0;
      miscompares   = 0;
      override_en   = 1'b0;
      override_addr = 32'h10;
      override_data = 32'hFFFF_FFFF;
      reset = 1'b1; pc_enable = 1'b1; instr_enable = 1'b1;
      pc_src = 1'b0; jumpD = 1'b0; branch_target = 32'h0; jump_target = 32'h0;

      // Reset state
      applyStimulus(1, 1, 1, 0, 0, 32'h0, 32'h0);
      applyStimulus(1, 1, 1, 0, 0, 32'h0, 32'h0);
      checkState("reset", 32'h0, 32'h0, 32'h0, 0, 0);
      checkCounters("reset", 0, 0, 0);

      // Sequential fetch
      applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h0);
      checkState("seq0", 32'h4, 32'h0, 32'h4, 1, 0);
      applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h0);
      checkState("seq1", 32'h8, 32'h1, 32'h8, 1, 0);
      checkCounters("seq1", 0, 0, 2);

      // Load-use stall at pc 8
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
      checkState("stall", 32'h8, 32'h1, 32'h8, 1, 0);
      checkCounters("stall", 1, 0, 2);
      applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h0);
      checkState("resume", 32'hC, 32'h2, 32'hC, 1, 0);

      // Taken branch
      applyStimulus(0, 1, 1, 1, 0, 32'h40, 32'h0);
      checkState("branch", 32'h40, 32'h0, 32'h0, 0, 0);
      checkCounters("branch", 1, 1, 3);

      // Jump and branch together: jump wins
      applyStimulus(0, 1, 1, 1, 1, 32'h40, 32'h100);
      checkState("both", 32'h100, 32'h0, 32'h0, 0, 0);
      checkCounters("both", 1, 2, 3);

      // Jump to the halt location
      override_en = 1'b1;
      applyStimulus(0, 1, 1, 0, 1, 32'h0, 32'h10);
      checkState("jmp10", 32'h10, 32'h0, 32'h0, 0, 0);

      // HALT_WORD flushed by a branch to itself: no halt
      applyStimulus(0, 1, 1, 1, 0, 32'h10, 32'h0);
      checkState("flushhalt", 32'h10, 32'h0, 32'h0, 0, 0);

      // HALT_WORD present but IF/ID held: no halt
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
      checkState("heldhalt", 32'h10, 32'h0, 32'h0, 0, 0);
      checkCounters("heldhalt", 2, 4, 3);

      // HALT_WORD loaded: halts, PC frozen
      applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h0);
      checkState("halt", 32'h10, 32'hFFFF_FFFF, 32'h14, 1, 1);
      checkCounters("halt", 2, 4, 4);

      // Redirects ignored in HALTED, bubbles follow
      applyStimulus(0, 1, 1, 1, 1, 32'h40, 32'h100);
      checkState("haltredir", 32'h10, 32'h0, 32'h0, 0, 1);
      applyStimulus(0, 0, 1, 0, 0, 32'h0, 32'h0);
      checkState("haltstall", 32'h10, 32'h0, 32'h0, 0, 1);
      checkCounters("haltstall", 2, 4, 4);

      // Reset mid-halt
      override_en = 1'b0;
      applyStimulus(1, 0, 0, 1, 1, 32'h40, 32'h100);
      checkState("haltreset", 32'h0, 32'h0, 32'h0, 0, 0);
      checkCounters("haltreset", 0, 0, 0);
      applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h0);
      checkState("rerun", 32'h4, 32'h0, 32'h4, 1, 0);

      // PC wrap from 0xFFFF_FFFC
      applyStimulus(0, 1, 1, 0, 1, 32'h0, 32'hFFFF_FFFC);
      checkState("jmpTop", 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0);
      applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h0);
      checkState("wrap", 32'h0, 32'h3FFF_FFFF, 32'h0, 1, 0);
      checkCounters("wrap", 0, 1, 2);

      // Reset mid-stall
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
      applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'h0);
      checkState("stallreset", 32'h0, 32'h0, 32'h0, 0, 0);
      checkCounters("stallreset", 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, instruction encoding that stops fetch.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pc_enable  input  1  from hazard unit; 0 holds the PC.
REQ-006 SHALL have port instr_enable  input  1  from hazard unit; 0 holds the IF/ID register.
REQ-007 SHALL have port pc_src  input  1  taken branch resolved in decode.
REQ-008 SHALL have port jumpD  input  1  jump in decode.
REQ-009 SHALL have port branch_target  input  32  branch destination address.
REQ-010 SHALL have port jump_target  input  32  fully formed jump destination address.
REQ-011 SHALL have port instr_mem_data  input  32  combinational instruction-memory read data at pc_out.
REQ-012 SHALL have port pc_out  output  32  current PC, drives the instruction-memory address.
REQ-013 SHALL have port instrD  output  32  IF/ID instruction.
REQ-014 SHALL have port pc_plus4D  output  32  IF/ID PC+4.
REQ-015 SHALL have port validD  output  1  IF/ID holds a real fetched instruction.
REQ-016 SHALL have port halted  output  1  fetch FSM is in HALTED.
REQ-017 SHALL have ports stall_cnt, flush_cnt, fetch_cnt  output  32 each  performance counters (REQ-032).

Function
REQ-018 SHALL compute pc+4 modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-019 SHALL select next PC by priority: reset > FSM HALTED (hold) > pc_enable=0 (hold) > jumpD (jump_target) > pc_src (branch_target) > pc+4.
REQ-020 SHALL treat jumpD and pc_src both high as a jump: jump_target wins.
REQ-021 SHALL update IF/ID by priority: reset > instr_enable=0 (hold all fields) > flush > load.
REQ-022 SHALL flush when pc_src or jumpD is high in RUN: instrD=32'h0, pc_plus4D=0, validD=0.
REQ-023 SHALL load in RUN when not held and not flushed: instrD=instr_mem_data, pc_plus4D=pc+4, validD=1.
REQ-024 SHALL load a bubble in HALTED when instr_enable=1: instrD=0, pc_plus4D=0, validD=0.
REQ-025 SHALL have a two-state FSM: RUN and HALTED.
REQ-026 SHALL move RUN->HALTED on the edge where a load (REQ-023) captures instr_mem_data==HALT_WORD.
REQ-027 SHALL not halt on a HALT_WORD that is flushed or held, and SHALL not halt on a HALT_WORD that is not loaded.
REQ-028 SHALL leave HALTED only through reset, and SHALL ignore pc_src, jumpD and pc_enable while in HALTED.
REQ-029 SHALL have a fetch latency of one cycle: the instr_mem_data present during cycle N appears on instrD in cycle N+1.
REQ-030 SHALL keep the PC frozen at the HALT_WORD address in HALTED, and SHALL raise halted the cycle after the load.

Reset
REQ-031 SHALL, on reset=1 at a rising edge, set pc_out=RESET_PC, instrD=0, pc_plus4D=0, validD=0, FSM=RUN, halted=0, all counters=0, overriding every other input, including when reset arrives mid-stall or mid-halt.

Configuration
REQ-032 SHALL implement the performance counters only when macro FETCH_PERF_CNT_EN is defined.
- With the macro: stall_cnt increments in RUN on cycles with pc_enable=0; flush_cnt increments on flush cycles; fetch_cnt increments on loads; all counters wrap at 2^32.
- Without the macro: the three ports remain present and are tied to constant 0, with no counter flops.

Verification
REQ-033 SHALL cover sequential fetch: reset, memory returns i at address 4i -> pc_out 0,4,8,...; instrD equals prior-cycle data; validD=1 from the second cycle.
REQ-034 SHALL cover load-use stall: pc_enable=0 and instr_enable=0 for 1 cycle at pc=8 -> pc_out stays 8, and IF/ID holds for that cycle.
REQ-035 SHALL cover a taken branch: pc_src=1 with branch_target=32'h40 -> next pc_out=32'h40, instrD=0, validD=0, and flush_cnt+1 (macro on).
REQ-036 SHALL cover simultaneous redirects: jumpD=1 and pc_src=1 with jump_target=32'h100 and branch_target=32'h40 -> pc_out=32'h100.
REQ-037 SHALL cover halt: HALT_WORD at 32'h10 -> instrD=32'hFFFF_FFFF, then halted=1, pc_out held at 32'h10, and bubbles follow; reset then restores RUN at RESET_PC.
REQ-038 SHALL cover flushed halt and wrap: HALT_WORD fetched while pc_src=1 -> no halt; and pc_out=32'hFFFF_FFFC followed by sequential fetch -> pc_out=0.
